// File: rtl/axis_s_rx_fifo.sv
// axis_s_rx_fifo: AXI-Stream slave receive buffer.
// Accepts beats from an upstream AXI-Stream master into a first-word-fall-through
// FIFO, exposes a pop interface to the consumer and counts completed packets.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module axis_s_rx_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int PKT_CNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     tvalid,
  output logic                     tready,
  input  logic [DATA_W-1:0]        tdata,
  input  logic                     tlast,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [PKT_CNT_W-1:0]     pkt_cnt,
  output logic                     pkt_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);

  // Storage: payload plus its tlast flag; no reset so it maps onto plain RAM.
  logic [DATA_W:0]        mem [DEPTH];

  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [AW:0]            fill_reg;
  logic [PKT_CNT_W-1:0]   pkt_cnt_reg;
  logic                   pkt_done_reg;
  logic                   ready_en_reg;

  logic                   push;
  logic                   pop;

  // Ready depends only on registers, never on tvalid, so there is no
  // combinational loop back to the upstream master.
  assign tready   = ready_en_reg && (fill_reg != FILL_FULL);
  assign rd_valid = (fill_reg != '0);

  // Pop is qualified by rd_valid, so rd_en on an empty FIFO is a no-op even
  // when a push lands in the same cycle.
  assign push = tvalid && tready;
  assign pop  = rd_en && rd_valid;

  // First-word-fall-through: head entry is shown directly from memory.
  assign {rd_last, rd_data} = mem[rd_ptr_reg];

  assign fill     = fill_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign pkt_done = pkt_done_reg;

  // Write the accepted beat and its tlast flag at the write pointer.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {tlast, tdata};
    end
  end

  // Write pointer advances on every accepted beat, wrapping modulo DEPTH.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_reg <= '0;
    end else if (push) begin
      wr_ptr_reg <= wr_ptr_reg + AW'(1);
    end
  end

  // Read pointer advances on every pop, wrapping modulo DEPTH.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_ptr_reg <= '0;
    end else if (pop) begin
      rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Occupancy: the only source of full/empty; unchanged on push+pop.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      fill_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
        2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // Packet counter and one-cycle completion pulse for each accepted tlast beat.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      pkt_cnt_reg  <= '0;
      pkt_done_reg <= 1'b0;
    end else begin
      pkt_done_reg <= push && tlast;
      if (push && tlast) begin
        pkt_cnt_reg <= pkt_cnt_reg + PKT_CNT_W'(1);
      end
    end
  end

  // Hold tready low until the first clock edge after reset release.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_s_rx_fifo.sv
// tb_axis_s_rx_fifo: randomized and directed stimulus for axis_s_rx_fifo,
// checked every cycle against a queue-based model of the receive buffer.
module tb_axis_s_rx_fifo;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int PKT_CNT_W = 16;

  logic                  aclk;
  logic                  areset_n;
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic                  tlast;
  logic                  rd_en;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_last;
  logic [3:0]            fill;
  logic [PKT_CNT_W-1:0]  pkt_cnt;
  logic                  pkt_done;

  int errors = 0;
  int checks = 0;

  axis_s_rx_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PKT_CNT_W (PKT_CNT_W)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .fill     (fill),
    .pkt_cnt  (pkt_cnt),
    .pkt_done (pkt_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model: contents as a queue, plus counters.
  logic [DATA_W:0]       q[$];
  bit                    m_ready_en = 1'b0;
  logic [PKT_CNT_W-1:0]  m_cnt = '0;
  bit                    m_done = 1'b0;
  bit                    m_push;
  bit                    m_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  // Model update on each clock edge, cleared at once by reset.
  initial begin
    forever begin
      @(posedge aclk or negedge areset_n);
      if (!areset_n) begin
        q.delete();
        m_ready_en = 1'b0;
        m_cnt      = '0;
        m_done     = 1'b0;
      end else begin
        m_push = tvalid && m_ready_en && (q.size() < DEPTH);
        m_pop  = rd_en && (q.size() > 0);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back({tlast, tdata});
        m_done = m_push && tlast;
        if (m_done) m_cnt = m_cnt + 1'b1;
        m_ready_en = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge aclk) begin
    chk("tready",   64'(tready),   64'(m_ready_en && (q.size() != DEPTH)));
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("fill",     64'(fill),     64'(q.size()));
    chk("pkt_cnt",  64'(pkt_cnt),  64'(m_cnt));
    chk("pkt_done", 64'(pkt_done), 64'(m_done));
    if (q.size() != 0) begin
      chk("rd_data", 64'(rd_data), 64'(q[0][DATA_W-1:0]));
      chk("rd_last", 64'(rd_last), 64'(q[0][DATA_W]));
    end
  end

  initial begin
    logic [31:0] drain_exp [8];
    int pulses;

    areset_n = 1'b0;
    tvalid   = 1'b1;
    tdata    = 32'h11;
    tlast    = 1'b0;
    rd_en    = 1'b0;

    // Reset release: tready held low in reset and until the first edge after.
    repeat (4) begin
      step();
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_fill",   64'(fill),   64'd0);
    end
    areset_n = 1'b1;
    #1;
    chk("rel_tready_pre", 64'(tready), 64'd0);
    step();
    chk("rel_tready_post", 64'(tready), 64'd1);
    chk("rel_fill",        64'(fill),   64'd0);
    tvalid = 1'b0;
    $display("reset released, tready=%0b", tready);

    // Single-beat packet.
    tvalid = 1'b1; tdata = 32'hAAAABBBB; tlast = 1'b1;
    step();
    tvalid = 1'b0; tlast = 1'b0;
    $display("push data=0x%08h last=1", 32'hAAAABBBB);
    chk("single_rd_valid", 64'(rd_valid), 64'd1);
    chk("single_rd_data",  64'(rd_data),  64'hAAAABBBB);
    chk("single_rd_last",  64'(rd_last),  64'd1);
    chk("single_fill",     64'(fill),     64'd1);
    chk("single_pkt_done", 64'(pkt_done), 64'd1);
    chk("single_pkt_cnt",  64'(pkt_cnt),  64'd1);
    step();
    chk("single_pkt_done_off", 64'(pkt_done), 64'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    $display("pop data=0x%08h", 32'hAAAABBBB);
    chk("single_pop_fill",     64'(fill),     64'd0);
    chk("single_pop_rd_valid", 64'(rd_valid), 64'd0);

    // Fill to full, blocked ninth beat, then one pop lets it in.
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b1; tdata = 32'(i); tlast = (i == 7);
      step();
      $display("push data=0x%08h last=%0b", i, i == 7);
    end
    tdata = 32'hCCCCDDDD; tlast = 1'b0; tvalid = 1'b1;
    chk("full_fill",   64'(fill),   64'd8);
    chk("full_tready", 64'(tready), 64'd0);
    step();
    chk("full_hold_fill", 64'(fill),    64'd8);
    chk("full_head",      64'(rd_data), 64'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("full_pop_fill",   64'(fill),    64'd7);
    chk("full_pop_head",   64'(rd_data), 64'd1);
    chk("full_pop_tready", 64'(tready),  64'd1);
    step();
    tvalid = 1'b0;
    $display("push data=0x%08h last=0", 32'hCCCCDDDD);
    chk("refill_fill",   64'(fill),   64'd8);
    chk("refill_tready", 64'(tready), 64'd0);
    chk("refill_cnt",    64'(pkt_cnt), 64'd2);
    for (int k = 0; k < 7; k++) drain_exp[k] = 32'(k + 1);
    drain_exp[7] = 32'hCCCCDDDD;
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", 64'(rd_data), 64'(drain_exp[k]));
      chk("drain_last", 64'(rd_last), 64'(k == 6));
      $display("pop data=0x%08h last=%0b", rd_data, rd_last);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("drain_fill", 64'(fill), 64'd0);

    // Streaming with continuous push and pop.
    for (int i = 0; i < 20; i++) begin
      tvalid = 1'b1; rd_en = 1'b1; tdata = 32'(i); tlast = 1'b0;
      step();
      chk("stream_fill", 64'(fill),    64'd1);
      chk("stream_head", 64'(rd_data), 64'(i));
      $display("stream push/pop data=0x%08h", i);
    end
    tvalid = 1'b0;
    step();
    rd_en = 1'b0;
    chk("stream_end_fill", 64'(fill), 64'd0);

    // Randomized traffic, alternating pop-heavy and push-heavy phases.
    for (int c = 0; c < 3000; c++) begin
      tvalid = ($urandom_range(0, 99) < 70);
      rd_en  = ($urandom_range(0, 99) < (((c / 300) % 2) != 0 ? 85 : 30));
      tdata  = $urandom;
      tlast  = ($urandom_range(0, 3) == 0);
      step();
    end
    $display("random phase done, pkt_cnt=%0d", pkt_cnt);

    // Drain, then fill to 5 and reset asynchronously between edges.
    tvalid = 1'b0; rd_en = 1'b1;
    repeat (DEPTH + 1) step();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1; tdata = 32'h5000 + 32'(i); tlast = (i == 2);
      step();
    end
    tvalid = 1'b0;
    chk("pre_rst_fill", 64'(fill), 64'd5);
    #2;
    areset_n = 1'b0;
    #1;
    $display("mid-operation reset asserted");
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_tready",   64'(tready),   64'd0);
    chk("mid_rst_fill",     64'(fill),     64'd0);
    chk("mid_rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    step();
    step();
    areset_n = 1'b1;
    step();
    tvalid = 1'b1; tdata = 32'h12345678; tlast = 1'b0;
    step();
    tvalid = 1'b0;
    $display("push data=0x%08h last=0", 32'h12345678);
    chk("post_rst_data", 64'(rd_data), 64'h12345678);
    chk("post_rst_fill", 64'(fill),    64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;

    // Packet counter wrap: 2^16 back-to-back tlast beats.
    pulses = 0;
    for (int i = 0; i < 65536; i++) begin
      tvalid = 1'b1; rd_en = 1'b1; tlast = 1'b1; tdata = 32'(i);
      step();
      if (pkt_done === 1'b1) pulses++;
      if (i == 65534) chk("wrap_cnt_max", 64'(pkt_cnt), 64'hFFFF);
    end
    tvalid = 1'b0; tlast = 1'b0;
    step();
    rd_en = 1'b0;
    $display("wrap phase done, pulses=%0d pkt_cnt=%0d", pulses, pkt_cnt);
    chk("wrap_cnt_zero", 64'(pkt_cnt), 64'd0);
    chk("wrap_pulses",   64'(pulses),  64'd65536);
    chk("wrap_fill",     64'(fill),    64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
